// File: rtl/immediate_decode_stage.sv
// RV immediate decoder with a registered 2-entry skid buffer on the output side.
// Optional macro IMM_FORMAT_CHECK_EN adds a format_error flag carried with each entry.
module immediate_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     full_instruction,
  input  logic [2:0]      immediate_source,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] immediate_extended,
  output logic            format_error
);

  // state  | meaning
  // EMPTY  | no result held
  // ONE    | result in output register, skid free
  // TWO    | output register and skid both hold results, upstream stalled
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic            r_in_ready;
  logic [XLEN-1:0] r_out_imm;
  logic [XLEN-1:0] r_skid_imm;
  logic [XLEN-1:0] w_dec_imm;
  logic            w_accept;
  logic            w_xfer;
  logic            w_load_out_dec;
  logic            w_load_out_skid;
  logic            w_load_skid;
  logic            w_unused_opcode;

  // opcode bits never contribute to an immediate
  assign w_unused_opcode = ^full_instruction[6:0];

  always_comb begin
    w_dec_imm = '0;
    case (immediate_source)
      3'b000: w_dec_imm = XLEN'($signed(full_instruction[31:20]));
      3'b001: w_dec_imm = XLEN'($signed({full_instruction[31:25], full_instruction[11:7]}));
      3'b010: w_dec_imm = XLEN'($signed({full_instruction[31], full_instruction[7],
                                         full_instruction[30:25], full_instruction[11:8], 1'b0}));
      3'b011: w_dec_imm = XLEN'($signed({full_instruction[31:12], 12'b0}));
      3'b100: w_dec_imm = XLEN'($signed({full_instruction[31], full_instruction[19:12],
                                         full_instruction[20], full_instruction[30:21], 1'b0}));
      3'b101: w_dec_imm = XLEN'(full_instruction[19:15]);
      default: w_dec_imm = '0;
    endcase
  end

  assign w_accept = in_valid && r_in_ready;
  assign w_xfer   = out_ready && (r_state != S_EMPTY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_load_out_dec  = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_next_state   = S_ONE;
          w_load_out_dec = 1'b1;
        end
      end
      S_ONE: begin
        if (w_accept && !w_xfer) begin
          w_next_state = S_TWO;
          w_load_skid  = 1'b1;
        end else if (!w_accept && w_xfer) begin
          w_next_state = S_EMPTY;
        end else if (w_accept && w_xfer) begin
          w_load_out_dec = 1'b1;
        end
      end
      S_TWO: begin
        // upstream is stalled here, so only a drain can happen
        if (w_xfer) begin
          w_next_state    = S_ONE;
          w_load_out_skid = 1'b1;
        end
      end
      default: w_next_state = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready <= 1'b0;
      r_out_imm  <= '0;
      r_skid_imm <= '0;
    end else begin
      r_in_ready <= (w_next_state != S_TWO);
      if (w_load_out_dec) begin
        r_out_imm <= w_dec_imm;
      end else if (w_load_out_skid) begin
        r_out_imm <= r_skid_imm;
      end
      if (w_load_skid) begin
        r_skid_imm <= w_dec_imm;
      end
    end
  end

`ifdef IMM_FORMAT_CHECK_EN
  logic w_dec_err;
  logic r_out_err;
  logic r_skid_err;

  assign w_dec_err = immediate_source[2] & immediate_source[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_err  <= 1'b0;
      r_skid_err <= 1'b0;
    end else begin
      if (w_load_out_dec) begin
        r_out_err <= w_dec_err;
      end else if (w_load_out_skid) begin
        r_out_err <= r_skid_err;
      end
      if (w_load_skid) begin
        r_skid_err <= w_dec_err;
      end
    end
  end

  assign format_error = r_out_err;
`else
  assign format_error = 1'b0;
`endif

  assign in_ready           = r_in_ready;
  assign out_valid          = (r_state != S_EMPTY);
  assign immediate_extended = r_out_imm;

endmodule

// File: tb/tb_immediate_decode_stage.sv
// Scoreboard bench: XLEN=32 and XLEN=64 instances share stimulus; an arithmetic
// reference model predicts each accepted entry and a negedge monitor checks outputs.
module tb_immediate_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] inst;
  logic [2:0]  src;

  logic        ir32, ov32, fe32;
  logic        ir64, ov64, fe64;
  logic [31:0] imm32;
  logic [63:0] imm64;

  always #5 clk = ~clk;

  immediate_decode_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32),
    .full_instruction(inst), .immediate_source(src), .out_valid(ov32),
    .out_ready(out_ready), .immediate_extended(imm32), .format_error(fe32)
  );

  immediate_decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir64),
    .full_instruction(inst), .immediate_source(src), .out_valid(ov64),
    .out_ready(out_ready), .immediate_extended(imm64), .format_error(fe64)
  );

  typedef struct packed {
    logic [63:0] imm;
    logic        err;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: rebuild the immediate's numeric value from weighted fields, then
  // subtract the sign weight when inst[31] is set.
  function automatic exp_t model(input logic [31:0] x, input logic [2:0] s);
    longint v;
    exp_t   e;
    v     = 0;
    e.err = 1'b0;
    case (s)
      3'd0: begin v = longint'(x[31:20]); if (x[31]) v -= 4096; end
      3'd1: begin v = longint'({x[31:25], x[11:7]}); if (x[31]) v -= 4096; end
      3'd2: begin
        v = 2 * longint'(x[11:8]) + 32 * longint'(x[30:25]) + 2048 * longint'(x[7]);
        if (x[31]) v -= 4096;
      end
      3'd3: begin v = longint'(x[31:12]) * 4096; if (x[31]) v -= (longint'(1) << 32); end
      3'd4: begin
        v = 2 * longint'(x[30:21]) + 2048 * longint'(x[20]) + 4096 * longint'(x[19:12]);
        if (x[31]) v -= (longint'(1) << 20);
      end
      3'd5: v = longint'(x[19:15]);
      default: begin
        v = 0;
`ifdef IMM_FORMAT_CHECK_EN
        e.err = 1'b1;
`endif
      end
    endcase
    e.imm = v;
    return e;
  endfunction

  function automatic void qpush(input int d, input exp_t e);
    if (d == 0) q32.push_back(e);
    else q64.push_back(e);
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q32.size() : q64.size();
  endfunction

  function automatic exp_t qpop(input int d);
    return (d == 0) ? q32.pop_front() : q64.pop_front();
  endfunction

  logic        dv   [2];
  logic        dr   [2];
  logic        derr [2];
  logic [63:0] dimm [2];
  assign dv[0] = ov32;  assign dv[1] = ov64;
  assign dr[0] = ir32;  assign dr[1] = ir64;
  assign derr[0] = fe32; assign derr[1] = fe64;
  assign dimm[0] = {32'b0, imm32};
  assign dimm[1] = imm64;

  logic        held_v   [2];
  logic [63:0] held_imm [2];
  logic        held_err [2];
  logic        lat_pend [2];

  always @(negedge clk) begin
    if (!rst_n) begin
      q32.delete();
      q64.delete();
      for (int d = 0; d < 2; d++) begin
        held_v[d]   <= 1'b0;
        lat_pend[d] <= 1'b0;
        held_imm[d] <= '0;
        held_err[d] <= 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        exp_t e;
        if (lat_pend[d] === 1'b1) check("latency_out_valid", 64'(dv[d]), 64'd1);
        if (held_v[d] === 1'b1) begin
          check("hold_valid", 64'(dv[d]), 64'd1);
          check("hold_imm", dimm[d], held_imm[d]);
          check("hold_err", 64'(derr[d]), 64'(held_err[d]));
        end
        if (dv[d] && out_ready) begin
          if (qsize(d) == 0) begin
            n_total++;
            $display("FAIL unexpected_output dut%0d: got imm %h expected no output", d, dimm[d]);
          end else begin
            e = qpop(d);
            check(d == 0 ? "imm32" : "imm64", dimm[d], d == 0 ? {32'b0, e.imm[31:0]} : e.imm);
            check("format_error", 64'(derr[d]), 64'(e.err));
          end
        end
        held_v[d]   <= dv[d] && !out_ready;
        held_imm[d] <= dimm[d];
        held_err[d] <= derr[d];
        lat_pend[d] <= in_valid && dr[d] && !dv[d];
        if (in_valid && dr[d]) qpush(d, model(inst, src));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] vec_inst [8];
  logic [2:0]  vec_src  [8];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; inst = '0; src = '0;
    vec_inst = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h123450B7,
                 32'h8000006F, 32'h000F8000, 32'h12345678, 32'h87654321};
    vec_src  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7, 3'd6};

    #2;
    check("rst_out_valid32", 64'(ov32), 64'd0);
    check("rst_in_ready32", 64'(ir32), 64'd0);
    check("rst_imm32", 64'(imm32), 64'd0);
    check("rst_err32", 64'(fe32), 64'd0);
    check("rst_out_valid64", 64'(ov64), 64'd0);
    check("rst_in_ready64", 64'(ir64), 64'd0);
    check("rst_imm64", imm64, 64'd0);
    check("rst_err64", 64'(fe64), 64'd0);

    step();
    rst_n = 1'b1;
    step();
    check("in_ready_after_release32", 64'(ir32), 64'd1);
    check("in_ready_after_release64", 64'(ir64), 64'd1);

    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; inst = vec_inst[i]; src = vec_src[i];
      step();
    end
    in_valid = 1'b0;
    step(); step();

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; inst = $urandom; src = 3'($urandom_range(0, 7));
      if (i == 2) begin
        check("stall_in_ready32", 64'(ir32), 64'd0);
        check("stall_in_ready64", 64'(ir64), 64'd0);
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("drain_consecutive32", 64'(ov32), 64'd1);
      check("drain_consecutive64", 64'(ov64), 64'd1);
    end
    step(); step();

    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; inst = $urandom; src = 3'($urandom_range(0, 5));
      step();
    end
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid32", 64'(ov32), 64'd0);
    check("async_rst_out_valid64", 64'(ov64), 64'd0);
    check("async_rst_imm64", imm64, 64'd0);
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_rst_idle32", 64'(ov32), 64'd0);
      check("post_rst_idle64", 64'(ov64), 64'd0);
    end

    repeat (400) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      inst      = $urandom;
      src       = 3'($urandom_range(0, 7));
      step();
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (q32.size() == 0 && q64.size() == 0) break;
      step();
    end
    check("final_queue32_empty", 64'(q32.size()), 64'd0);
    check("final_queue64_empty", 64'(q64.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
